button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Multi-channel front end for the parking-meter push buttons (coin, time-select, confirm, cancel).
- Each channel synchronizes the raw pin, debounces it, and emits a single-cycle press pulse.
- Each channel can optionally emit auto-repeat pulses while the button is held.
- Sits between the board pins and the meter control FSM. Pulse outputs go directly to the control FSM's one-cycle event inputs.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a level change (>=1).
- REPEAT_DELAY, 50000, cycles from initial press pulse to first repeat pulse (>=2).
- REPEAT_PERIOD, 10000, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  N_CH  raw asynchronous button pins, active-high.
- repeat_en  in  N_CH  per-channel auto-repeat enable, synchronous to clk.
- btn_level  out  N_CH  debounced, registered button level.
- btn_pulse  out  N_CH  registered one-cycle press and repeat pulses.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1, all registers are 0 immediately: sync flops, debounce counter, btn_level, FSM=IDLE, repeat counter, btn_pulse. btn_pulse and btn_level read 0 without waiting for a clock edge.
- Channels are fully independent. No cross-channel arbitration. Simultaneous events on different channels are all reported in the same cycle.
- Synchronizer: 2-flop chain per channel. sync = second flop.
- Debounce, evaluated at every edge:
  - if sync != level: if cnt == DEBOUNCE_CYCLES-1, then level <= sync and cnt <= 0; else cnt <= cnt+1.
  - if sync == level: cnt <= 0.
- Latency: btn_raw sampled high at edge k and held gives btn_level=1 after edge k+DEBOUNCE_CYCLES+1. Release has the same latency.
- Glitch filtering: a raw high of DEBOUNCE_CYCLES-1 cycles or less is rejected. A raw high of exactly DEBOUNCE_CYCLES cycles is accepted.
- Per-channel pulse FSM states: IDLE, HELD, REPEAT.
  - IDLE: on the edge where level goes 0->1, btn_pulse=1 for that cycle, rcnt <= 0, go to HELD.
  - HELD: if level=0, go to IDLE. Else if repeat_en=0, rcnt <= 0 and stay. Else if rcnt == REPEAT_DELAY-1, pulse, rcnt <= 0, go to REPEAT. Else rcnt++.
  - REPEAT: if level=0, go to IDLE. Else if repeat_en=0, rcnt <= 0 and go to HELD. Else if rcnt == REPEAT_PERIOD-1, pulse and rcnt <= 0. Else rcnt++.
- Pulse timing: the initial pulse coincides with the first cycle of btn_level=1. The first repeat pulse is exactly REPEAT_DELAY cycles after the initial pulse; later repeats are every REPEAT_PERIOD cycles.
- No pulse on release. btn_pulse is never high for two consecutive cycles unless REPEAT_PERIOD=1.
- Dropping repeat_en mid-hold stops pulses from the next edge. Re-asserting it restarts the full REPEAT_DELAY.
- Reset mid-operation: a button still held when rst deasserts is treated as a new press. It produces a pulse DEBOUNCE_CYCLES+2 edges after reset release.
- Widths:
  - Debounce counter: max(1, $clog2(DEBOUNCE_CYCLES)) bits.
  - Repeat counter: max(1, $clog2(max(REPEAT_DELAY, REPEAT_PERIOD))) bits.
  - Counters never wrap; they are cleared explicitly as above.

Decomposition:
- Package btn_pkg holds:
  - FSM state encoding localparams: IDLE=2'd0, HELD=2'd1, REPEAT=2'd2. Unused encoding 2'd3 recovers to IDLE.
  - A clog2-with-minimum-1 width function.
- Sub-module btn_channel: one synchronizer, debouncer, and FSM. It takes the three timing parameters and is instantiated N_CH times via generate. The top is generate wiring only.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, N_CH=4.
- Clean press, ch0: btn_raw[0] high from edge 0 for 20 cycles, repeat_en=0 -> btn_level[0] and btn_pulse[0] rise after edge 5. Pulse lasts 1 cycle with no further pulses. After release, level falls 6 edges later with no pulse.
- Bounce, ch1: btn_raw[1] toggles every 2 cycles for 20 cycles, then held low -> btn_level[1] stays 0 and btn_pulse[1] stays 0.
- Glitch threshold, ch2: a 3-cycle raw high is rejected (no level change). A 4-cycle raw high gives level=1 for 4 cycles and exactly one pulse.
- Auto-repeat, ch3: repeat_en[3]=1, held 30 cycles with initial pulse at cycle P -> pulses at P, P+8, P+11, P+14, ... while held. Dropping repeat_en at P+12 -> no pulse at P+14.
- Simultaneous: all four channels pressed at the same edge -> all btn_pulse bits high in the same single cycle.
- Reset mid-hold: rst asserted during REPEAT on ch0 between edges -> btn_pulse and btn_level go to 0 without a clock edge. rst released with raw still high -> new pulse 6 edges after release.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and helpers for the button conditioner: pulse
//               FSM state encoding and counter width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Pulse FSM state encoding; 2'd3 is unused and recovers to IDLE.
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end
        return $clog2(value);
    endfunction

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module      : btn_channel
// Description : One button channel: 2-flop synchronizer, stable-count
//               debouncer and press/auto-repeat pulse FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
    localparam int RW = clog2_min1(max2(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE      = DW'(1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_ONE     = RW'(1);

    logic            sync_meta;
    logic            sync;
    logic [DW-1:0]   db_cnt;
    logic [RW-1:0]   rcnt;
    btn_state_e      state;
    logic            rise;

    // Two-flop synchronizer bringing the asynchronous pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Accept a new level only after it has differed from the current one
    // for DEBOUNCE_CYCLES consecutive edges; any agreeing sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync != level) begin
            if (db_cnt == DB_LAST) begin
                level  <= sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Debounced level is about to go 0->1 on this edge; lets the press pulse
    // line up with the first cycle of level=1.
    assign rise = sync & ~level & (db_cnt == DB_LAST);

    // Press / auto-repeat pulse FSM with registered one-cycle pulse output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        pulse <= 1'b1;
                        rcnt  <= '0;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (!level) begin
                        // With very short debounce a new press can land on
                        // the same edge the release is seen; do not lose it.
                        if (rise) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!repeat_en) begin
                        rcnt <= '0;
                    end else if (rcnt == DELAY_LAST) begin
                        pulse <= 1'b1;
                        rcnt  <= '0;
                        state <= REPEAT;
                    end else begin
                        rcnt <= rcnt + RPT_ONE;
                    end
                end
                REPEAT: begin
                    if (!level) begin
                        if (rise) begin
                            pulse <= 1'b1;
                            rcnt  <= '0;
                            state <= HELD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!repeat_en) begin
                        rcnt  <= '0;
                        state <= HELD;
                    end else if (rcnt == PERIOD_LAST) begin
                        pulse <= 1'b1;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + RPT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end

endmodule : btn_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : N_CH independent button channels (sync, debounce, press and
//               auto-repeat pulses) for the parking-meter front panel.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse
);

    // One fully independent channel per button; no cross-channel logic.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .raw       (btn_raw[i]),
            .repeat_en (repeat_en[i]),
            .level     (btn_level[i]),
            .pulse     (btn_pulse[i])
        );
    end

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner: directed press,
//               bounce, glitch, auto-repeat, simultaneous and reset-mid-hold
//               scenarios, then random stimulus against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam logic [63:0] WIN_MASK = (64'd1 << D) - 64'd1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw   = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    button_conditioner #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;
    int t       = 0;
    int pcnt [N];

    // Reference model: raw/sync sample histories, accepted level, and for
    // each channel the edge of the last timing anchor plus the gap to the
    // next expected pulse.
    logic [63:0]  raw_hist  [N];
    logic [63:0]  sync_hist [N];
    logic [N-1:0] m_level;
    logic [N-1:0] m_pulse;
    int           anchor    [N];
    int           gap       [N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            raw_hist[c]  = '0;
            sync_hist[c] = '0;
            anchor[c]    = 0;
            gap[c]       = RD;
        end
        m_level = '0;
        m_pulse = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            logic old;
            raw_hist[c]  = {raw_hist[c][62:0], btn_raw[c]};
            // Value leaving the synchronizer: pin as sampled two edges ago.
            sync_hist[c] = {sync_hist[c][62:0], raw_hist[c][2]};
            old = m_level[c];
            // Level flips when the last D synchronized samples all disagree.
            if (((sync_hist[c] ^ {64{old}}) & WIN_MASK) == WIN_MASK)
                m_level[c] = ~old;
            m_pulse[c] = 1'b0;
            if (!old && m_level[c]) begin
                m_pulse[c] = 1'b1;
                anchor[c]  = t;
                gap[c]     = RD;
            end else if (old) begin
                if (!repeat_en[c]) begin
                    anchor[c] = t;
                    gap[c]    = RD;
                end else if (t - anchor[c] == gap[c]) begin
                    m_pulse[c] = 1'b1;
                    anchor[c]  = t;
                    gap[c]     = RP;
                end
            end
        end
        t++;
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: got %b, expected %b", tag, ecount, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model, then compare once outputs settle.
    task automatic tick();
        @(posedge clk);
        ecount++;
        if (!rst) model_edge();
        #1;
        check_vec("level", btn_level, m_level);
        check_vec("pulse", btn_pulse, m_pulse);
        for (int c = 0; c < N; c++)
            if (btn_pulse[c]) pcnt[c]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int e0, first, p0, lvl_cycles, max_lvl, found;
        int pidx [$];

        for (int c = 0; c < N; c++) pcnt[c] = 0;
        model_reset();

        // ---- Reset state ----
        idle(2);
        check_vec("reset_level", btn_level, '0);
        check_vec("reset_pulse", btn_pulse, '0);
        rst = 1'b0;
        idle(4);

        // ---- Clean press on ch0, no repeat ----
        p0 = pcnt[0];
        btn_raw[0] = 1'b1;
        e0 = ecount;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (btn_level[0] && first < 0) first = ecount - e0 - 1;
        end
        check_int("press_level_edge", first, 5);
        check_int("press_pulse_count", pcnt[0] - p0, 1);
        btn_raw[0] = 1'b0;
        e0 = ecount;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!btn_level[0] && first < 0) first = ecount - e0 - 1;
        end
        check_int("release_level_edge", first, 5);
        check_int("release_no_pulse", pcnt[0] - p0, 1);

        // ---- Bounce on ch1 ----
        p0 = pcnt[1];
        max_lvl = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw[1] = (i < 20) && (((i / 2) % 2) == 0);
            tick();
            if (btn_level[1]) max_lvl = 1;
        end
        check_int("bounce_level", max_lvl, 0);
        check_int("bounce_pulse", pcnt[1] - p0, 0);

        // ---- Glitch threshold on ch2 ----
        p0 = pcnt[2];
        lvl_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            btn_raw[2] = (i < 3);
            tick();
            if (btn_level[2]) lvl_cycles++;
        end
        check_int("glitch3_level", lvl_cycles, 0);
        check_int("glitch3_pulse", pcnt[2] - p0, 0);
        for (int i = 0; i < 20; i++) begin
            btn_raw[2] = (i < 4);
            tick();
            if (btn_level[2]) lvl_cycles++;
        end
        check_int("glitch4_level_cycles", lvl_cycles, 4);
        check_int("glitch4_pulse", pcnt[2] - p0, 1);

        // ---- Auto-repeat on ch3, repeat_en dropped at P+12 ----
        repeat_en[3] = 1'b1;
        btn_raw[3]   = 1'b1;
        e0 = ecount;
        for (int i = 0; i < 30; i++) begin
            int idx;
            tick();
            idx = ecount - e0 - 1;
            if (btn_pulse[3]) pidx.push_back(idx);
            if (pidx.size() > 0 && idx == pidx[0] + 11) repeat_en[3] = 1'b0;
        end
        check_int("repeat_count", pidx.size(), 3);
        check_int("repeat_p0",  (pidx.size() > 0) ? pidx[0] : -1, 5);
        check_int("repeat_p8",  (pidx.size() > 1) ? pidx[1] : -1, 13);
        check_int("repeat_p11", (pidx.size() > 2) ? pidx[2] : -1, 16);
        btn_raw[3] = 1'b0;
        idle(12);

        // ---- Simultaneous press on all channels ----
        btn_raw = '1;
        idle(5);
        check_vec("simul_before", btn_pulse, '0);
        tick();
        check_vec("simul_pulse", btn_pulse, '1);
        tick();
        check_vec("simul_after", btn_pulse, '0);
        idle(4);
        btn_raw = '0;
        idle(12);

        // ---- Reset asserted mid-repeat on ch0 ----
        repeat_en[0] = 1'b1;
        btn_raw[0]   = 1'b1;
        idle(20);
        check_int("rst_pre_pulse", int'(btn_pulse[0]), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_vec("rst_async_level", btn_level, '0);
        check_vec("rst_async_pulse", btn_pulse, '0);
        idle(3);
        rst = 1'b0;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (btn_pulse[0] && found < 0) found = i + 1;
        end
        check_int("rst_release_pulse_edge", found, 6);
        btn_raw      = '0;
        repeat_en    = '0;
        idle(12);

        // ---- Random stimulus against the model ----
        for (int i = 0; i < 800; i++) begin
            int lim;
            lim = (i < 400) ? 5 : 19;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, lim) == 0) btn_raw[c] = ~btn_raw[c];
                if ($urandom_range(0, 39) == 0)  repeat_en[c] = ~repeat_en[c];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
